// File: rtl/pipe_pkg.sv
// Shared types and constants for the integer pipeline sequencing logic.
// The scoreboard entry mirrors what ID/EX carries about a destination register.
package pipe_pkg;

    localparam logic [4:0]  REG_ZERO         = 5'd0;
    localparam int          LINK_REG_DEFAULT = 31;
    localparam logic [14:0] NOP_CTRL         = {9'b0, 6'h15};

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_SQUASH = 2'd2
    } state_e;

    function automatic logic reg_match(input sb_entry_t e, input logic [4:0] r);
        return e.valid && (e.dest == r) && (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/dest_scoreboard.sv
// Three-deep record of destinations in flight through EX/MEM/WB plus the
// source-operand hazard compare; it shifts every cycle since the back end never stalls.
module dest_scoreboard
    import pipe_pkg::*;
#(
    parameter int FORWARD   = 0,
    parameter int WB_BYPASS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_valid,
    input  logic [4:0] push_dest,
    input  logic       push_load,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       uses_rs,
    input  logic       uses_rt,
    output logic       hazard
);

    // index 0 = EX, 1 = MEM, 2 = WB
    sb_entry_t sb_q [3];
    sb_entry_t sb_d [3];

    assign sb_d[0] = {push_valid, push_dest, push_load};

    genvar gi;
    generate
        for (gi = 1; gi < 3; gi++) begin : g_shift
            assign sb_d[gi] = sb_q[gi-1];
        end
        for (gi = 0; gi < 3; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (reset) begin
                    sb_q[gi] <= '0;
                end else begin
                    sb_q[gi] <= sb_d[gi];
                end
            end
        end
    endgenerate

    // With bypassing only a load still in EX cannot deliver its result in time.
    function automatic logic src_hazard(input logic [4:0] r);
        if (FORWARD != 0) begin
            return reg_match(sb_q[0], r) && sb_q[0].load;
        end
        return reg_match(sb_q[0], r) || reg_match(sb_q[1], r) ||
               ((WB_BYPASS == 0) && reg_match(sb_q[2], r));
    endfunction

    assign hazard = (uses_rs && src_hazard(rs)) || (uses_rt && src_hazard(rt));

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-side sequencing controller: holds IF/ID and bubbles ID/EX on data
// hazards, squashes the wrong-path fetch after a taken redirect, counts both.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FORWARD   = 0,
    parameter int WB_BYPASS = 1,
    parameter int LINK_REG  = LINK_REG_DEFAULT,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_wreg,
    input  logic             id_writes,
    input  logic             id_is_load,
    input  logic             id_redirect,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    generate
        if (LINK_REG < 1 || LINK_REG > 31) begin : g_bad_link
            $error("hazard_ctrl: LINK_REG must name a writable register (1..31)");
        end
    endgenerate

    state_e           state_q, state_d;
    logic             hazard;
    logic             stall_req;
    logic             hold_c, bubble_c, flush_c;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    dest_scoreboard #(
        .FORWARD   (FORWARD),
        .WB_BYPASS (WB_BYPASS)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .push_valid (id_valid && id_writes && (id_wreg != REG_ZERO) && !bubble_c),
        .push_dest  (id_wreg),
        .push_load  (id_is_load),
        .rs         (id_rs),
        .rt         (id_rt),
        .uses_rs    (id_uses_rs),
        .uses_rt    (id_uses_rt),
        .hazard     (hazard)
    );

    assign stall_req = hazard && id_valid;

    // STALL releases with the same rules as RUN, so both share one branch.
    always_comb begin
        state_d  = state_q;
        hold_c   = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        case (state_q)
            ST_SQUASH: begin
                bubble_c = 1'b1;
                state_d  = ST_RUN;
            end
            default: begin
                if (stall_req) begin
                    hold_c   = 1'b1;
                    bubble_c = 1'b1;
                    state_d  = ST_STALL;
                end else if (id_redirect) begin
                    flush_c = 1'b1;
                    state_d = ST_SQUASH;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    assign pc_hold     = hold_c   && !reset;
    assign ifid_hold   = hold_c   && !reset;
    assign idex_bubble = bubble_c && !reset;
    assign ifid_flush  = flush_c  && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, pc_hold};
            flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, ifid_flush};
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
